al_time_entry: RTL and testbench
================================

// Module: al_time_entry
// PURPOSE
//  Keypad time-entry stage for the alarm clock. Collects BCD digit keystrokes into a
//  4-digit HH:MM buffer and validates it on a LOAD key. A valid entry drives time_out and
//  a 1-cycle load_new_time strobe. These connect directly to the clock counter's
//  time_in / load_new_time. An entry with no keystroke for TIMEOUT_SECS is abandoned.
// PARAMETERS
//  TIMEOUT_SECS  10     one_second ticks with no keystroke before the entry is abandoned
//  TIMER_WIDTH   4      width of the inactivity counter; must hold TIMEOUT_SECS
//  KEY_CLEAR     4'hA   key_code that clears the entry
//  KEY_LOAD      4'hB   key_code that validates and loads the entry
// PORTS
//  clk            in   1   system clock; all state changes on posedge
//  reset          in   1   synchronous, active-high reset
//  key_valid      in   1   1-cycle strobe; key_code is valid this cycle
//  key_code       in   4   0-9 digit, KEY_CLEAR, KEY_LOAD; other codes ignored
//  one_second     in   1   1-cycle tick, once per second
//  key_buffer     out  16  digits entered so far, BCD {d3,d2,d1,d0}; for the display
//  entry_active   out  1   high while in ENTRY state
//  time_out       out  16  last accepted time, BCD HHMM; feeds the counter's time_in
//  load_new_time  out  1   1-cycle strobe; time_out is valid the same cycle
//  entry_error    out  1   1-cycle strobe; LOAD was rejected
// BEHAVIOUR
//  Reset (sync, wins over all inputs):
//   - state=IDLE, key_buffer=16'h0000, digit count=0, timer=0
//   - time_out=16'h1200; load_new_time=0, entry_error=0
//   - a strobe pending from the previous cycle is suppressed
//  FSM states: IDLE, ENTRY. entry_active = (state==ENTRY).
//  Digit key (0-9):
//   - key_buffer <= {key_buffer[11:0], key_code}
//   - count <= min(count+1, 4); on the 5th and later digits the oldest digit falls off
//   - timer <= 0; IDLE->ENTRY or stay in ENTRY
//  KEY_CLEAR, any state: key_buffer=0, count=0, timer=0, state->IDLE. No strobe.
//  KEY_LOAD in IDLE: ignored; no strobe, no error.
//  KEY_LOAD in ENTRY: entry valid only if all of:
//   - count==4
//   - d3<=2; if d3==2 then d2<=3
//   - d1<=5
//  Valid LOAD: on the next edge
//   - time_out <= key_buffer; load_new_time=1 for exactly 1 cycle
//   - key_buffer=0, count=0, state->IDLE
//   - latency: the strobe is high in the cycle after the key_valid cycle
//  Invalid LOAD: on the next edge
//   - entry_error=1 for exactly 1 cycle; time_out unchanged
//   - key_buffer=0, count=0, state->IDLE
//  Codes C-F: ignored entirely; timer is not restarted.
//  Timeout, in ENTRY:
//   - each one_second tick increments timer
//   - the tick that makes timer==TIMEOUT_SECS clears key_buffer and count, state->IDLE, no strobe
//   - in IDLE, timer holds 0
//  Simultaneous key_valid and one_second: the key is processed; timer <= 0; the tick is dropped.
//  load_new_time and entry_error are never high in the same cycle.
//  time_out changes only on reset or a valid LOAD.
// TESTING
//  1 Keys 1,2,3,4,LOAD -> next cycle: load_new_time=1 (1 cycle), time_out=16'h1234,
//    key_buffer=0, entry_active=0
//  2 Keys 2,4,0,0,LOAD -> entry_error=1 (1 cycle), load_new_time stays 0,
//    time_out stays 16'h1200; keys 1,7,6,0,LOAD -> entry_error (d1=6)
//  3 Keys 1,2,3,LOAD -> entry_error (count=3); then 1,2,3,4,5,LOAD -> time_out=16'h2345
//  4 Keys 0,7 then 9 one_second ticks -> entry_active=1, key_buffer=16'h0007;
//    10th tick -> entry_active=0, key_buffer=0
//  5 Keys 0,7; 9 ticks; key 3 in the same cycle as a tick; 9 more ticks ->
//    still active, key_buffer=16'h0073; 10th tick -> IDLE
//  6 Keys 1,2,3,4,LOAD then reset on the edge where the strobe would rise ->
//    no load_new_time, time_out=16'h1200, all outputs at reset values

Source files
------------

// File: rtl/al_time_entry_if.sv
// al_time_entry_if: keypad/time-entry bus; master drives keys and ticks, slave returns buffer, status and loaded time
//   key_valid, key_code, one_second     : master -> slave
//   key_buffer, entry_active, time_out,
//   load_new_time, entry_error          : slave -> master
interface al_time_entry_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        one_second;
    logic [15:0] key_buffer;
    logic        entry_active;
    logic [15:0] time_out;
    logic        load_new_time;
    logic        entry_error;
    modport master (
        output key_valid, key_code, one_second,
        input  key_buffer, entry_active, time_out, load_new_time, entry_error
    );
    modport slave (
        input  key_valid, key_code, one_second,
        output key_buffer, entry_active, time_out, load_new_time, entry_error
    );
endinterface

// File: rtl/al_time_entry.sv
// al_time_entry: collects BCD keystrokes into HH:MM, validates on LOAD, abandons idle entries
//   clk, reset : clock, synchronous active-high reset
//   bus        : al_time_entry_if.slave (keys/ticks in; buffer, status, time and strobes out)
module al_time_entry #(
    parameter int         TIMEOUT_SECS = 10,
    parameter int         TIMER_WIDTH  = 4,
    parameter logic [3:0] KEY_CLEAR    = 4'hA,
    parameter logic [3:0] KEY_LOAD     = 4'hB
) (
    input  logic            clk,
    input  logic            reset,
    al_time_entry_if.slave  bus
);
    typedef enum logic {IDLE, ENTRY} state_t;
    state_t                 r_state;
    logic [15:0]            r_buf;
    logic [2:0]             r_cnt;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [15:0]            r_time_out;
    logic                   r_load;
    logic                   r_err;
    logic                   w_digit;
    logic                   w_valid;
    assign w_digit = bus.key_valid && (bus.key_code <= 4'd9);
    // d0/d2 are always 0-9 because only digit keys are shifted in
    assign w_valid = (r_cnt == 3'd4) && (r_buf[15:12] <= 4'd2) &&
                     ((r_buf[15:12] != 4'd2) || (r_buf[11:8] <= 4'd3)) &&
                     (r_buf[7:4] <= 4'd5);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_time_out <= 16'h1200;
            r_load     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_load <= 1'b0;
            r_err  <= 1'b0;
            if (w_digit) begin
                r_buf   <= {r_buf[11:0], bus.key_code};
                r_cnt   <= (r_cnt == 3'd4) ? 3'd4 : r_cnt + 3'd1;
                r_timer <= '0;
                r_state <= ENTRY;
            end else if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
                r_buf   <= '0;
                r_cnt   <= '0;
                r_timer <= '0;
                r_state <= IDLE;
            end else if (bus.key_valid && bus.key_code == KEY_LOAD && r_state == ENTRY) begin
                if (w_valid) r_time_out <= r_buf;
                r_load  <= w_valid;
                r_err   <= !w_valid;
                r_buf   <= '0;
                r_cnt   <= '0;
                r_timer <= '0;
                r_state <= IDLE;
            end else if (r_state == ENTRY && bus.one_second) begin
                // the tick that reaches the limit abandons the entry and rearms the timer
                if (r_timer == TIMER_WIDTH'(TIMEOUT_SECS - 1)) begin
                    r_buf   <= '0;
                    r_cnt   <= '0;
                    r_timer <= '0;
                    r_state <= IDLE;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
            end
        end
    end
    assign bus.key_buffer    = r_buf;
    assign bus.entry_active  = (r_state == ENTRY);
    assign bus.time_out      = r_time_out;
    assign bus.load_new_time = r_load;
    assign bus.entry_error   = r_err;
endmodule

// File: tb/tb_al_time_entry.sv
// tb_al_time_entry: directed and randomized checks of al_time_entry against a queue-based reference model
module tb_al_time_entry;
    logic clk = 1'b0;
    logic reset = 1'b1;
    al_time_entry_if bus ();
    al_time_entry dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    int          total = 0;
    int          bad = 0;
    int          q[$];
    int          tmr = 0;
    bit          act = 0;
    logic [15:0] tout = 16'h1200;
    bit          mld = 0;
    bit          mer = 0;
    function automatic logic [15:0] qbuf();
        logic [15:0] b = 16'h0;
        foreach (q[i]) b = (b << 4) | 16'(q[i]);
        return b;
    endfunction
    task automatic model(input bit kv, input int kc, input bit sec, input bit rst);
        int hh, mm;
        mld = 0;
        mer = 0;
        if (rst) begin
            q.delete(); tmr = 0; act = 0; tout = 16'h1200;
        end else if (kv && kc <= 9) begin
            q.push_back(kc);
            if (q.size() > 4) void'(q.pop_front());
            tmr = 0; act = 1;
        end else if (kv && kc == 10) begin
            q.delete(); tmr = 0; act = 0;
        end else if (kv && kc == 11 && act) begin
            if (q.size() == 4) begin
                hh = q[0] * 10 + q[1];
                mm = q[2] * 10 + q[3];
            end
            if (q.size() == 4 && hh <= 23 && mm <= 59) begin
                tout = qbuf(); mld = 1;
            end else mer = 1;
            q.delete(); tmr = 0; act = 0;
        end else if (act && sec) begin
            tmr++;
            if (tmr == 10) begin
                q.delete(); tmr = 0; act = 0;
            end
        end
    endtask
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag);
        chk({tag, ".buf"}, bus.key_buffer, qbuf());
        chk({tag, ".act"}, 16'(bus.entry_active), 16'(act));
        chk({tag, ".tout"}, bus.time_out, tout);
        chk({tag, ".load"}, 16'(bus.load_new_time), 16'(mld));
        chk({tag, ".err"}, 16'(bus.entry_error), 16'(mer));
    endtask
    task automatic step(input bit kv, input int kc, input bit sec, input bit rst, input string tag);
        bus.key_valid  = kv;
        bus.key_code   = 4'(kc);
        bus.one_second = sec;
        reset          = rst;
        @(posedge clk);
        model(kv, kc, sec, rst);
        #1;
        bus.key_valid  = 1'b0;
        bus.one_second = 1'b0;
        reset          = 1'b0;
        chk_all(tag);
    endtask
    task automatic key(input int k, input string tag);
        step(1, k, 0, 0, tag);
    endtask
    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, tag);
    endtask
    initial begin
        int kp, r, kc;
        bit kv, sec, rs;
        bus.key_valid = 1'b0;
        bus.key_code = 4'h0;
        bus.one_second = 1'b0;
        step(0, 0, 0, 1, "reset");
        chk("reset.tout_const", bus.time_out, 16'h1200);
        // valid load
        key(1, "t1"); key(2, "t1"); key(3, "t1"); key(4, "t1"); key(11, "t1");
        chk("t1.load_const", 16'(bus.load_new_time), 16'h1);
        chk("t1.tout_const", bus.time_out, 16'h1234);
        step(0, 0, 0, 0, "t1.after");
        chk("t1.load_drop", 16'(bus.load_new_time), 16'h0);
        // hours too large, minutes too large
        step(0, 0, 0, 1, "t2.rst");
        key(2, "t2"); key(4, "t2"); key(0, "t2"); key(0, "t2"); key(11, "t2");
        chk("t2.err_const", 16'(bus.entry_error), 16'h1);
        chk("t2.tout_const", bus.time_out, 16'h1200);
        key(1, "t2b"); key(7, "t2b"); key(6, "t2b"); key(0, "t2b"); key(11, "t2b");
        chk("t2b.err_const", 16'(bus.entry_error), 16'h1);
        // short entry, then overflow shifting out the oldest digit
        key(1, "t3"); key(2, "t3"); key(3, "t3"); key(11, "t3");
        chk("t3.err_const", 16'(bus.entry_error), 16'h1);
        for (int d = 1; d <= 5; d++) key(d, "t3b");
        key(11, "t3b");
        chk("t3b.tout_const", bus.time_out, 16'h2345);
        // LOAD in IDLE, C-F ignored, CLEAR
        key(11, "idle_load"); key(12, "ign"); key(15, "ign");
        key(9, "clr"); key(10, "clr");
        chk("clr.act_const", 16'(bus.entry_active), 16'h0);
        // timeout
        key(0, "t4"); key(7, "t4"); ticks(9, "t4");
        chk("t4.act_const", 16'(bus.entry_active), 16'h1);
        chk("t4.buf_const", bus.key_buffer, 16'h0007);
        ticks(1, "t4.to");
        chk("t4.to_act_const", 16'(bus.entry_active), 16'h0);
        // key coincident with tick restarts the timer
        key(0, "t5"); key(7, "t5"); ticks(9, "t5");
        step(1, 3, 1, 0, "t5.both");
        ticks(9, "t5");
        chk("t5.buf_const", bus.key_buffer, 16'h0073);
        ticks(1, "t5.to");
        chk("t5.to_act_const", 16'(bus.entry_active), 16'h0);
        // ignored code does not restart the timer
        key(5, "ign_t"); ticks(5, "ign_t"); key(13, "ign_t"); ticks(5, "ign_t");
        // reset on the strobe edge
        key(1, "t6"); key(2, "t6"); key(3, "t6"); key(4, "t6");
        step(1, 11, 0, 1, "t6.rst");
        chk("t6.load_const", 16'(bus.load_new_time), 16'h0);
        chk("t6.tout_const", bus.time_out, 16'h1200);
        step(0, 0, 0, 0, "t6.after");
        // randomized phases: busy typing, slow typing, near-silent (timeouts)
        for (int i = 0; i < 3000; i++) begin
            kp = ((i / 300) % 3 == 0) ? 50 : ((i / 300) % 3 == 1) ? 10 : 2;
            kv = ($urandom_range(0, 99) < kp);
            r  = $urandom_range(0, 99);
            kc = (r < 70) ? $urandom_range(0, 9) : (r < 82) ? 11 : (r < 90) ? 10 : $urandom_range(12, 15);
            if (kv && r < 70 && $urandom_range(0, 3) == 0) kc = (q.size() % 2 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 5);
            sec = ($urandom_range(0, 99) < 30);
            rs  = ($urandom_range(0, 199) == 0);
            step(kv, kc, sec, rs, "rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
